// File: rtl/chan_sequencer_pkg.sv
// chan_sequencer_pkg: shared state encoding and widths for the channel sequencer
package chan_sequencer_pkg;
  localparam int SEL_W = 4;
  localparam int NUM_CH_DEF = 6;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/chan_sequencer_dwell_counter.sv
// dwell_counter: loadable up-counter that wraps to 0 on reaching its latched limit
module dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] limit_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic               term_o
);
  logic [DWELL_W-1:0] cnt_q, lim_q;
  assign term_o = cnt_q == lim_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      lim_q <= limit_i;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= term_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/chan_sequencer.sv
// chan_sequencer: steps a registered channel select through 0..NUM_CH-1 with a programmable dwell
module chan_sequencer
  import chan_sequencer_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             sel_en_q, busy_q, done_q, wrap_q, mode_q, term;
  logic             load, clr, inc;
  assign load = state_q == ST_IDLE && start && !stop;
  assign clr  = state_q == ST_RUN && stop;
  assign inc  = state_q == ST_RUN && !stop;
  dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .limit_i (dwell),
    .clr_i   (clr),
    .inc_i   (inc),
    .term_o  (term)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sel_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (load) begin
          state_q  <= ST_RUN;
          sel_q    <= '0;
          sel_en_q <= 1'b1;
          busy_q   <= 1'b1;
          mode_q   <= mode_cont;
        end
        ST_RUN: if (stop) begin
          state_q  <= ST_IDLE;
          sel_q    <= '0;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end else if (term) begin
          if (sel_q != LAST) begin
            sel_q <= sel_q + 1'b1;
          end else if (mode_q) begin
            sel_q  <= '0;
            wrap_q <= 1'b1;
          end else begin
            state_q  <= ST_DONE;
            sel_en_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          sel_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;
endmodule

// File: tb/tb_chan_sequencer.sv
// tb_chan_sequencer: directed checks of scan timing, modes, abort and reset
module tb_chan_sequencer;
  localparam int DW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    sel;
  logic          sel_en, busy, done, wrap;
  int            n_chk = 0, n_err = 0;

  chan_sequencer #(.NUM_CH(6), .DWELL_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .dwell     (dwell),
    .sel       (sel),
    .sel_en    (sel_en),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sel"}, 32'(sel), 0);
    chk({tag, ".en"}, 32'(sel_en), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".wrap"}, 32'(wrap), 0);
  endtask

  task automatic go(input logic m, input logic [DW-1:0] d);
    mode_cont = m;
    dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // single-shot dwell=2 with mid-scan start, dwell and mode changes ignored
    go(1'b0, 4'd2);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("ss.sel%0d", i), 32'(sel), 32'(i / 3));
      chk($sformatf("ss.en%0d", i), 32'({sel_en, busy, done, wrap}), 32'b1100);
      start = (i == 4);
      if (i == 1) begin
        dwell = 4'd7;
        mode_cont = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk("ss.done_en", 32'({sel_en, busy, done, wrap}), 32'b0110);
    chk("ss.done_sel", 32'(sel), 5);
    tick();
    chk_idle("ss.after");

    // start+stop collision in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk_idle("collide");

    // continuous dwell=0
    go(1'b1, 4'd0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("ct.sel%0d", i), 32'(sel), 32'(i % 6));
      chk($sformatf("ct.wrap%0d", i), 32'(wrap), 32'(i > 0 && i % 6 == 0));
      chk($sformatf("ct.done%0d", i), 32'({sel_en, busy, done}), 32'b110);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("ct.stop");

    // abort while sel=2, dwell=1
    go(1'b0, 4'd1);
    repeat (4) tick();
    chk("ab.sel_pre", 32'(sel), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("ab");
    go(1'b0, 4'd1);
    chk("ab.restart_sel", 32'(sel), 0);
    chk("ab.restart_en", 32'(sel_en), 1);
    tick();
    tick();
    chk("ab.restart_sel1", 32'(sel), 1);

    // async reset mid-scan at sel=3
    tick();
    tick();
    tick();
    tick();
    chk("rs.sel_pre", 32'(sel), 3);
    chk("rs.en_pre", 32'(sel_en), 1);
    rst = 1'b1;
    #1;
    chk_idle("rs.async");
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk_idle("rs.after");

    // max dwell on the 4-bit counter
    go(1'b0, 4'd15);
    for (int i = 0; i < 96; i++) begin
      chk($sformatf("mx.sel%0d", i), 32'(sel), 32'(i / 16));
      chk($sformatf("mx.en%0d", i), 32'({sel_en, done}), 32'b10);
      tick();
    end
    chk("mx.done", 32'({sel_en, busy, done}), 32'b011);
    tick();
    chk_idle("mx.after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
